word_sel: RTL and testbench
===========================

WORD_SEL -- requirements
Module: word_sel

Interface
REQ-001 Parameter LEN, default 4: number of character slots in the entry buffer, legal range 1..16.
REQ-002 Parameter LO, default 7'h41: lowest selectable code ('A').
REQ-003 Parameter HI, default 7'h5A: highest selectable code ('Z'); LO < HI.
REQ-004 Parameter BLANK, default 7'h20: fill code for empty slots (space).
REQ-005 Port clk  input  1: single rising-edge clock.
REQ-006 Port rst  input  1: asynchronous, active-high reset.
REQ-007 Port adj  input  1: step the candidate character this cycle.
REQ-008 Port dir  input  1: step direction, 0 = up, 1 = down.
REQ-009 Port let_sel  input  1: commit the candidate into the next free slot.
REQ-010 Port del  input  1: backspace, removing the last committed slot.
REQ-011 Port clr  input  1: clear the whole buffer.
REQ-012 Port ascii  output  7: current candidate character.
REQ-013 Port word  output  7*LEN: slot k on bits [7k+6:7k]; slot 0 is the first entered.
REQ-014 Port count  output  $clog2(LEN+1): number of committed slots.
REQ-015 Port full  output  1: high while count == LEN.
REQ-016 Port done  output  1: one-cycle pulse on the cycle count becomes LEN.

Function
REQ-017 All inputs are single-cycle pulses sampled at posedge clk; all outputs are registered.
REQ-018 Candidate stepping: adj & !dir gives ascii+1, wrapping HI to LO; adj & dir gives ascii-1, wrapping LO to HI; !adj holds.
REQ-019 If ascii is outside [LO,HI], the next edge forces LO regardless of adj/dir.
REQ-020 State machine has two states. EDIT is entered on reset and while count < LEN; FULL holds while count == LEN.
REQ-021 Priority per cycle: clr > del > let_sel; candidate stepping is independent of this priority except on clr.
REQ-022 EDIT, let_sel: slot[count] <= ascii as sampled before any same-cycle step; count <= count+1; if the new count == LEN, go to FULL and pulse done.
REQ-023 FULL, let_sel: ignored; word and count are unchanged; no done pulse.
REQ-024 del with count > 0: slot[count-1] <= BLANK; count <= count-1; state becomes EDIT.
REQ-025 del with count == 0: no effect.
REQ-026 clr: all slots <= BLANK, count <= 0, ascii <= LO, state EDIT; any same-cycle adj is ignored.
REQ-027 Stepping (adj) is allowed in both states.
REQ-028 Latency from a command edge to visible ascii, word, count or full is one cycle; done asserts in the same cycle full first rises.
REQ-029 full is derived from state; it is never high in EDIT.

Reset
REQ-030 rst asserted clears immediately, independent of clk: ascii = LO, every slot = BLANK, count = 0, full = 0, done = 0, state EDIT.
REQ-031 rst asserted mid-entry discards all committed slots; no partial state survives.
REQ-032 After rst deasserts, the first active edge obeys the normal rules.

Structure
REQ-033 A shared package word_sel_pkg holds the state enum (EDIT, FULL) and default constants CH_LO, CH_HI, CH_BLANK.
REQ-034 Candidate stepping lives in sub-module char_step, parametrised by LO/HI, with ports clk, rst, adj, dir, clr, ascii.
REQ-035 The slot store is LEN 7-bit registers; no memory macro is used.

Verification
REQ-036 Wrap: reset, 25 up-adj pulses -> ascii 7'h5A; one more up-adj -> 7'h41; one down-adj -> 7'h5A.
REQ-037 Fill: commit at 'A','B','C','D' (LEN=4) -> word = {7'h44,7'h43,7'h42,7'h41}, count 4, full 1, done high exactly one cycle; a 5th let_sel changes nothing.
REQ-038 Simultaneous: let_sel+adj up with ascii 7'h47 -> slot gets 7'h47, ascii becomes 7'h48; del+let_sel with count 2 -> count 1, slot1 = 7'h20.
REQ-039 Backspace: from full, del -> count 3, full 0, slot3 = 7'h20; del at count 0 -> no change.
REQ-040 Clear/reset: clr+adj with count 3, ascii 7'h50 -> count 0, all slots 7'h20, ascii 7'h41; rst pulse between clock edges -> outputs at reset values before the next edge.
REQ-041 Parameter sweep: LEN=1, LO=7'h30, HI=7'h39 -> one commit sets full and done; stepping wraps '9' to '0'.

Source files
------------

// File: rtl/word_sel_pkg.sv
// Shared types and default character codes for the word entry block.
// Used by the top level and the candidate stepper.
package word_sel_pkg;

    typedef enum logic [0:0] {
        EDIT = 1'b0,
        FULL = 1'b1
    } state_t;

    localparam logic [6:0] CH_LO    = 7'h41;
    localparam logic [6:0] CH_HI    = 7'h5A;
    localparam logic [6:0] CH_BLANK = 7'h20;

endpackage

// File: rtl/word_sel_char_step.sv
// Candidate character register: steps up/down inside [LO,HI] with wrap.
// Out-of-range values snap to LO on the next edge.
module char_step
    import word_sel_pkg::*;
#(
    parameter logic [6:0] LO = CH_LO,
    parameter logic [6:0] HI = CH_HI
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       adj,
    input  logic       dir,
    input  logic       clr,
    output logic [6:0] ascii
);

    logic w_out_of_range;

    assign w_out_of_range = (ascii < LO) || (ascii > HI);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ascii <= LO;
        end else if (clr || w_out_of_range) begin
            ascii <= LO;
        end else if (adj) begin
            if (!dir) begin
                ascii <= (ascii == HI) ? LO : ascii + 7'd1;
            end else begin
                ascii <= (ascii == LO) ? HI : ascii - 7'd1;
            end
        end
    end

endmodule

// File: rtl/word_sel.sv
// Character-by-character word entry: candidate stepping, commit,
// backspace and clear into a LEN-slot buffer with a full/done flag.
module word_sel
    import word_sel_pkg::*;
#(
    parameter int         LEN   = 4,
    parameter logic [6:0] LO    = CH_LO,
    parameter logic [6:0] HI    = CH_HI,
    parameter logic [6:0] BLANK = CH_BLANK,
    localparam int        CW    = $clog2(LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adj,
    input  logic             dir,
    input  logic             let_sel,
    input  logic             del,
    input  logic             clr,
    output logic [6:0]       ascii,
    output logic [7*LEN-1:0] word,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             done
);

    state_t        r_state;
    logic [CW-1:0] r_count;
    logic          r_done;
    logic [6:0]    r_slot [LEN];

    char_step #(
        .LO (LO),
        .HI (HI)
    ) u_step (
        .clk   (clk),
        .rst   (rst),
        .adj   (adj),
        .dir   (dir),
        .clr   (clr),
        .ascii (ascii)
    );

    // Slot writes decode the count per slot so no array index is wider
    // than the slot range.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EDIT;
            r_count <= '0;
            r_done  <= 1'b0;
            for (int k = 0; k < LEN; k++) r_slot[k] <= BLANK;
        end else begin
            r_done <= 1'b0;
            if (clr) begin
                r_state <= EDIT;
                r_count <= '0;
                for (int k = 0; k < LEN; k++) r_slot[k] <= BLANK;
            end else if (del) begin
                if (r_count != '0) begin
                    for (int k = 0; k < LEN; k++) begin
                        if (CW'(k + 1) == r_count) r_slot[k] <= BLANK;
                    end
                    r_count <= r_count - 1'b1;
                    r_state <= EDIT;
                end
            end else if (let_sel && r_state == EDIT) begin
                for (int k = 0; k < LEN; k++) begin
                    if (CW'(k) == r_count) r_slot[k] <= ascii;
                end
                r_count <= r_count + 1'b1;
                if (r_count == CW'(LEN - 1)) begin
                    r_state <= FULL;
                    r_done  <= 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < LEN; k++) begin : g_word
        assign word[7*k +: 7] = r_slot[k];
    end

    assign count = r_count;
    assign full  = (r_state == FULL);
    assign done  = r_done;

endmodule

// File: tb/tb_word_sel.sv
// Directed self-checking bench for word_sel (default and LEN=1 digit build).
// Inputs are shared; the digit build is checked only at the end.
module tb_word_sel;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        adj = 1'b0;
    logic        dir = 1'b0;
    logic        let_sel = 1'b0;
    logic        del = 1'b0;
    logic        clr = 1'b0;

    logic [6:0]  ascii;
    logic [27:0] word;
    logic [2:0]  count;
    logic        full;
    logic        done;

    logic [6:0]  ascii2;
    logic [6:0]  word2;
    logic [0:0]  count2;
    logic        full2;
    logic        done2;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [6:0] B = 7'h20;

    always #5 clk = ~clk;

    word_sel dut (
        .clk     (clk),
        .rst     (rst),
        .adj     (adj),
        .dir     (dir),
        .let_sel (let_sel),
        .del     (del),
        .clr     (clr),
        .ascii   (ascii),
        .word    (word),
        .count   (count),
        .full    (full),
        .done    (done)
    );

    word_sel #(
        .LEN (1),
        .LO  (7'h30),
        .HI  (7'h39)
    ) dut2 (
        .clk     (clk),
        .rst     (rst),
        .adj     (adj),
        .dir     (dir),
        .let_sel (let_sel),
        .del     (del),
        .clr     (clr),
        .ascii   (ascii2),
        .word    (word2),
        .count   (count2),
        .full    (full2),
        .done    (done2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic a, input logic d, input logic l,
                        input logic dl, input logic c);
        adj = a; dir = d; let_sel = l; del = dl; clr = c;
        @(posedge clk);
        #1;
        adj = 0; dir = 0; let_sel = 0; del = 0; clr = 0;
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("rst_ascii", ascii, 7'h41);
        chk("rst_word", word, {B, B, B, B});
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 25; i++) step(1, 0, 0, 0, 0);
        chk("wrap_25up", ascii, 7'h5A);
        step(1, 0, 0, 0, 0);
        chk("wrap_hi_lo", ascii, 7'h41);
        step(1, 1, 0, 0, 0);
        chk("wrap_lo_hi", ascii, 7'h5A);
        step(1, 0, 0, 0, 0);
        chk("back_to_A", ascii, 7'h41);

        step(1, 0, 1, 0, 0);
        chk("fill1_word", word, {B, B, B, 7'h41});
        chk("fill1_ascii", ascii, 7'h42);
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        chk("fill3_count", count, 3);
        chk("fill3_done", done, 0);
        chk("fill3_full", full, 0);
        step(1, 0, 1, 0, 0);
        chk("fill4_word", word, {7'h44, 7'h43, 7'h42, 7'h41});
        chk("fill4_count", count, 4);
        chk("fill4_full", full, 1);
        chk("fill4_done", done, 1);
        chk("fill4_ascii", ascii, 7'h45);
        step(0, 0, 0, 0, 0);
        chk("done_one_cyc", done, 0);
        chk("full_holds", full, 1);
        step(0, 0, 1, 0, 0);
        chk("fill5_word", word, {7'h44, 7'h43, 7'h42, 7'h41});
        chk("fill5_count", count, 4);
        chk("fill5_done", done, 0);

        step(0, 0, 0, 1, 0);
        chk("bs_count", count, 3);
        chk("bs_full", full, 0);
        chk("bs_word", word, {B, 7'h43, 7'h42, 7'h41});
        step(0, 0, 0, 1, 0);
        chk("bs2_count", count, 2);
        step(0, 0, 1, 1, 0);
        chk("dl_let_count", count, 1);
        chk("dl_let_word", word, {B, B, B, 7'h41});

        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("pre_sim_ascii", ascii, 7'h47);
        step(1, 0, 1, 0, 0);
        chk("sim_word", word, {B, B, 7'h47, 7'h41});
        chk("sim_ascii", ascii, 7'h48);
        chk("sim_count", count, 2);

        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0);
        chk("pre_clr_count", count, 3);
        chk("pre_clr_ascii", ascii, 7'h50);
        step(1, 0, 0, 0, 1);
        chk("clr_count", count, 0);
        chk("clr_word", word, {B, B, B, B});
        chk("clr_ascii", ascii, 7'h41);
        step(0, 0, 0, 1, 0);
        chk("bs0_count", count, 0);
        chk("bs0_word", word, {B, B, B, B});

        step(0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("mid_count", count, 1);
        chk("mid_ascii", ascii, 7'h42);
        #2 rst = 1'b1;
        #1;
        chk("arst_ascii", ascii, 7'h41);
        chk("arst_count", count, 0);
        chk("arst_word", word, {B, B, B, B});
        chk("arst_full", full, 0);
        chk("arst2_ascii", ascii2, 7'h30);
        chk("arst2_full", full2, 0);
        rst = 1'b0;
        @(negedge clk);

        step(0, 0, 1, 0, 0);
        chk("post_rst_count", count, 1);
        chk("post_rst_word", word, {B, B, B, 7'h41});
        chk("l1_word", word2, 7'h30);
        chk("l1_count", count2, 1);
        chk("l1_full", full2, 1);
        chk("l1_done", done2, 1);
        for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 0);
        chk("l1_ascii9", ascii2, 7'h39);
        chk("l1_done_low", done2, 0);
        step(1, 0, 0, 0, 0);
        chk("l1_wrap", ascii2, 7'h30);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
